// File: rtl/seller_ctrl.sv
// Vending-sequence controller: debounces two coin channels, accumulates credit,
// drives the dispense window and pays back any excess as spaced change pulses.
module seller_ctrl #(
    parameter int DEB_CYCLES  = 2,
    parameter int PRICE       = 3,
    parameter int DISP_CYCLES = 4,
    parameter int CREDIT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1_n,
    input  logic                coin2_n,
    input  logic                cancel,
    output logic                pio_led,
    output logic                change_pulse,
    output logic                reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int DISP_W = $clog2(DISP_CYCLES + 1);

    localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]    DEB_ONE   = DEB_W'(1);
    localparam logic [DISP_W-1:0]   DISP_INIT = DISP_W'(DISP_CYCLES);
    localparam logic [DISP_W-1:0]   DISP_ONE  = DISP_W'(1);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CRED_ONE  = CREDIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    logic [1:0]        w_coin_n;
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_armed;
    logic [1:0]        r_evt;
    logic [DEB_W-1:0]  r_deb_cnt [2];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [DISP_W-1:0] r_disp_cnt;
    logic [DISP_W-1:0] w_disp_nxt;
    logic              r_phase;
    logic              w_phase_nxt;
    logic              r_pio;
    logic              w_pio_nxt;
    logic              r_chg;
    logic              w_chg_nxt;
    logic              r_rej;
    logic              w_rej_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic [CREDIT_W:0]   w_sum;
    logic                w_over;
    logic [CREDIT_W-1:0] w_sat;

    assign w_coin_n = {coin2_n, coin1_n};

    // Synchronize both coin pins and debounce them; bit 0 is the 1-unit coin, bit 1 the 2-unit coin.
    // The counter runs while the synchronized level differs from the armed state, so one
    // counter covers both the accept (low) and re-arm (high) qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_armed <= 2'b11;
            r_evt   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_coin_n;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] ^ r_armed[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb_cnt[i] <= '0;
                        r_armed[i]   <= ~r_armed[i];
                        r_evt[i]     <= r_armed[i];
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_ONE;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // The event vector doubles as the coin value: coin1 adds 1, coin2 adds 2, both add 3.
    always_comb begin
        w_sum  = {1'b0, r_credit} + {{(CREDIT_W - 1){1'b0}}, r_evt};
        w_over = w_sum[CREDIT_W];
        if (w_over) begin
            w_sat = {CREDIT_W{1'b1}};
        end else begin
            w_sat = w_sum[CREDIT_W-1:0];
        end
    end

    // Next-state and next-output logic for the vending sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_disp_nxt   = r_disp_cnt;
        w_phase_nxt  = 1'b0;
        w_pio_nxt    = 1'b0;
        w_chg_nxt    = 1'b0;
        w_rej_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_credit_nxt = w_sat;
                w_rej_nxt    = w_over;
                if (r_evt != 2'b00) begin
                    w_state_nxt = S_COLLECT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COLLECT: begin
                w_credit_nxt = w_sat;
                w_rej_nxt    = w_over;
                // Dispense wins over cancel; a coin landing this cycle still counts.
                if (r_credit >= PRICE_C) begin
                    w_state_nxt  = S_DISPENSE;
                    w_credit_nxt = w_sat - PRICE_C;
                    w_pio_nxt    = 1'b1;
                    w_disp_nxt   = DISP_INIT;
                end else if (cancel) begin
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DISPENSE: begin
                w_rej_nxt = |r_evt;
                if (r_disp_cnt <= DISP_ONE) begin
                    w_disp_nxt = '0;
                    if (r_credit != '0) begin
                        w_state_nxt = S_CHANGE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_pio_nxt  = 1'b1;
                    w_disp_nxt = r_disp_cnt - DISP_ONE;
                end
            end
            S_CHANGE: begin
                w_rej_nxt = |r_evt;
                if (r_credit == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_phase) begin
                    w_chg_nxt    = 1'b1;
                    w_credit_nxt = r_credit - CRED_ONE;
                    w_phase_nxt  = 1'b1;
                    if (r_credit == CRED_ONE) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CHANGE;
                    end
                end else begin
                    w_phase_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_credit   <= '0;
            r_disp_cnt <= '0;
            r_phase    <= 1'b0;
            r_pio      <= 1'b0;
            r_chg      <= 1'b0;
            r_rej      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_disp_cnt <= w_disp_nxt;
            r_phase    <= w_phase_nxt;
            r_pio      <= w_pio_nxt;
            r_chg      <= w_chg_nxt;
            r_rej      <= w_rej_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign pio_led      = r_pio;
    assign change_pulse = r_chg;
    assign reject       = r_rej;
    assign credit       = r_credit;
    assign busy         = r_busy;

endmodule

// File: tb/tb_seller_ctrl.sv
// Directed bench for seller_ctrl: default instance plus a PRICE=15 instance for saturation.
module tb_seller_ctrl;

    logic       clk = 1'b0;
    logic       rst, c1_n, c2_n, cancel;
    logic       pio, chg, rej, busy;
    logic [3:0] credit;
    logic       rst2, c1b_n, c2b_n, cancel2;
    logic       pio2, chg2, rej2, busy2;
    logic [3:0] credit2;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_no = 0;
    int n_pio, n_chg, n_rej, n_busy, chg_t0, chg_t1, rej_t, log_n;
    int n_pio2, n_chg2, n_rej2, n_busy2, rej2_t, sat_t;
    logic [63:0] log_v, log2;
    logic [3:0]  prev_cr, prev_cr2;

    seller_ctrl dut (
        .clk(clk), .rst(rst), .coin1_n(c1_n), .coin2_n(c2_n), .cancel(cancel),
        .pio_led(pio), .change_pulse(chg), .reject(rej), .credit(credit), .busy(busy)
    );

    seller_ctrl #(.DEB_CYCLES(2), .PRICE(15), .DISP_CYCLES(4), .CREDIT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .coin1_n(c1b_n), .coin2_n(c2b_n), .cancel(cancel2),
        .pio_led(pio2), .change_pulse(chg2), .reject(rej2), .credit(credit2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (pio)  n_pio++;
        if (busy) n_busy++;
        if (chg) begin n_chg++; chg_t0 = chg_t1; chg_t1 = tick_no; end
        if (rej) begin n_rej++; rej_t = tick_no; end
        if (credit !== prev_cr) begin log_v = {log_v[59:0], credit}; log_n++; prev_cr = credit; end
        if (pio2)  n_pio2++;
        if (chg2)  n_chg2++;
        if (busy2) n_busy2++;
        if (rej2) begin n_rej2++; rej2_t = tick_no; end
        if (credit2 !== prev_cr2) begin
            log2 = {log2[59:0], credit2};
            prev_cr2 = credit2;
            if (credit2 == 4'd15) sat_t = tick_no;
        end
    endtask

    task automatic clear_stats();
        n_pio = 0; n_chg = 0; n_rej = 0; n_busy = 0; chg_t0 = 0; chg_t1 = 0; rej_t = 0;
        log_v = 64'h0; log_n = 0; prev_cr = credit;
        n_pio2 = 0; n_chg2 = 0; n_rej2 = 0; n_busy2 = 0; rej2_t = 0; sat_t = -1;
        log2 = 64'h0; prev_cr2 = credit2;
    endtask

    task automatic coin(input logic [1:0] which, input int lo, input int hi);
        c1_n = ~which[0];
        c2_n = ~which[1];
        repeat (lo) tick();
        c1_n = 1'b1;
        c2_n = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; c1_n = 1'b0; c2_n = 1'b0; cancel = 1'b1;
        rst2 = 1'b1; c1b_n = 1'b1; c2b_n = 1'b1; cancel2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({pio, chg, rej, credit, busy} !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold cycle %0d: outputs=%b expected 00000000", i, {pio, chg, rej, credit, busy});
            end
        end
        rst = 1'b0; c1_n = 1'b1; c2_n = 1'b1; cancel = 1'b0; rst2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({pio, chg, rej, credit, busy} !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_release cycle %0d: outputs=%b expected 00000000", i, {pio, chg, rej, credit, busy});
            end
        end
    endtask

    task automatic test_exact_price();
        clear_stats();
        coin(2'b01, 5, 6);
        n_cmp++;
        if (credit !== 4'd1) begin n_bad++; $display("FAIL exact_credit1: got %0d expected 1", credit); end
        coin(2'b01, 5, 6);
        n_cmp++;
        if (credit !== 4'd2) begin n_bad++; $display("FAIL exact_credit2: got %0d expected 2", credit); end
        coin(2'b01, 5, 6);
        repeat (4) tick();
        n_cmp++;
        if (log_n !== 4 || log_v !== 64'h1230) begin
            n_bad++; $display("FAIL exact_credit_seq: got %0d entries %h expected 4 entries 1230", log_n, log_v);
        end
        n_cmp++;
        if (n_pio !== 4) begin n_bad++; $display("FAIL exact_pio_cycles: got %0d expected 4", n_pio); end
        n_cmp++;
        if (n_busy !== 4) begin n_bad++; $display("FAIL exact_busy_cycles: got %0d expected 4", n_busy); end
        n_cmp++;
        if (n_chg !== 0) begin n_bad++; $display("FAIL exact_change: got %0d expected 0", n_chg); end
        n_cmp++;
        if ({credit, busy} !== 5'b0) begin n_bad++; $display("FAIL exact_idle: credit=%0d busy=%b expected 0/0", credit, busy); end
    endtask

    task automatic test_overpay();
        clear_stats();
        coin(2'b10, 5, 6);
        n_cmp++;
        if (credit !== 4'd2) begin n_bad++; $display("FAIL overpay_credit2: got %0d expected 2", credit); end
        coin(2'b10, 5, 6);
        repeat (4) tick();
        n_cmp++;
        if (log_n !== 4 || log_v !== 64'h2410) begin
            n_bad++; $display("FAIL overpay_credit_seq: got %0d entries %h expected 4 entries 2410", log_n, log_v);
        end
        n_cmp++;
        if (n_pio !== 4) begin n_bad++; $display("FAIL overpay_pio_cycles: got %0d expected 4", n_pio); end
        n_cmp++;
        if (n_chg !== 1) begin n_bad++; $display("FAIL overpay_change: got %0d expected 1", n_chg); end
        n_cmp++;
        if (n_busy !== 5) begin n_bad++; $display("FAIL overpay_busy_cycles: got %0d expected 5", n_busy); end
        n_cmp++;
        if ({credit, busy} !== 5'b0) begin n_bad++; $display("FAIL overpay_idle: credit=%0d busy=%b expected 0/0", credit, busy); end
    endtask

    task automatic test_glitch_simul();
        clear_stats();
        coin(2'b01, 1, 6);
        n_cmp++;
        if (credit !== 4'd0 || log_n !== 0) begin
            n_bad++; $display("FAIL glitch_ignored: credit=%0d changes=%0d expected 0/0", credit, log_n);
        end
        clear_stats();
        coin(2'b11, 5, 6);
        repeat (4) tick();
        n_cmp++;
        if (log_n !== 2 || log_v !== 64'h30) begin
            n_bad++; $display("FAIL simul_credit_seq: got %0d entries %h expected 2 entries 30", log_n, log_v);
        end
        n_cmp++;
        if (n_pio !== 4 || n_chg !== 0) begin
            n_bad++; $display("FAIL simul_dispense: pio=%0d change=%0d expected 4/0", n_pio, n_chg);
        end
    endtask

    task automatic test_cancel();
        clear_stats();
        coin(2'b10, 5, 6);
        n_cmp++;
        if (credit !== 4'd2) begin n_bad++; $display("FAIL cancel_credit2: got %0d expected 2", credit); end
        // coin1 debounce event is timed to land while the refund is in progress
        c1_n = 1'b0;
        repeat (2) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        repeat (2) tick();
        c1_n = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if (n_chg !== 2 || (chg_t1 - chg_t0) !== 2) begin
            n_bad++; $display("FAIL cancel_pulses: count=%0d spacing=%0d expected 2/2", n_chg, chg_t1 - chg_t0);
        end
        n_cmp++;
        if (log_n !== 3 || log_v !== 64'h210) begin
            n_bad++; $display("FAIL cancel_credit_seq: got %0d entries %h expected 3 entries 210", log_n, log_v);
        end
        n_cmp++;
        if (n_pio !== 0) begin n_bad++; $display("FAIL cancel_no_pio: got %0d expected 0", n_pio); end
        n_cmp++;
        if (n_rej !== 1 || rej_t !== chg_t0 + 1) begin
            n_bad++; $display("FAIL cancel_reject: count=%0d at %0d expected 1 at %0d", n_rej, rej_t, chg_t0 + 1);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        c1_n = 1'b0; c2_n = 1'b0;
        repeat (5) tick();
        c1_n = 1'b1; c2_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (pio !== 1'b1) begin n_bad++; $display("FAIL midreset_in_dispense: pio=%b expected 1", pio); end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({pio, credit, busy} !== 6'b0) begin
            n_bad++; $display("FAIL midreset_cleared: pio=%b credit=%0d busy=%b expected 0/0/0", pio, credit, busy);
        end
        rst = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (n_chg !== 0 || n_pio !== 2 || credit !== 4'd0) begin
            n_bad++; $display("FAIL midreset_after: change=%0d pio=%0d credit=%0d expected 0/2/0", n_chg, n_pio, credit);
        end
    endtask

    task automatic test_saturation();
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            c2b_n = 1'b0;
            repeat (5) tick();
            c2b_n = 1'b1;
            repeat (6) tick();
        end
        repeat (6) tick();
        n_cmp++;
        if (log2 !== 64'h2468ACEF0) begin
            n_bad++; $display("FAIL sat_credit_seq: got %h expected 2468acef0", log2);
        end
        n_cmp++;
        if (n_rej2 !== 1 || rej2_t !== sat_t) begin
            n_bad++; $display("FAIL sat_reject: count=%0d at %0d expected 1 at %0d", n_rej2, rej2_t, sat_t);
        end
        n_cmp++;
        if (n_pio2 !== 4 || n_busy2 !== 4 || n_chg2 !== 0 || credit2 !== 4'd0) begin
            n_bad++; $display("FAIL sat_dispense: pio=%0d busy=%0d change=%0d credit=%0d expected 4/4/0/0",
                              n_pio2, n_busy2, n_chg2, credit2);
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_overpay();
        test_glitch_simul();
        test_cancel();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
